// File: rtl/c2h_stream_arbiter.sv
// Packet-granular round-robin arbiter feeding the XDMA C2H AXI-Stream port (user_clk_250 domain).
// state | meaning: IDLE pick next requester | FWD pass granted packet to C2H | DRAIN discard tail of a truncated packet
module c2h_stream_arbiter #(
    parameter int NUM_SRC    = 4,
    parameter int DATA_WIDTH = 256,
    parameter int MAX_BEATS  = 256,
    localparam int KEEP_WIDTH = DATA_WIDTH / 8,
    localparam int ID_WIDTH   = $clog2(NUM_SRC),
    localparam int CNT_WIDTH  = $clog2(MAX_BEATS) + 1
) (
    input  logic                             user_clk_250,
    input  logic                             sys_reset,
    input  logic                             arb_en,
    input  logic [NUM_SRC-1:0]               s_tvalid,
    output logic [NUM_SRC-1:0]               s_tready,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]    s_tdata,
    input  logic [NUM_SRC*KEEP_WIDTH-1:0]    s_tkeep,
    input  logic [NUM_SRC-1:0]               s_tlast,
    output logic                             m_tvalid,
    input  logic                             m_tready,
    output logic [DATA_WIDTH-1:0]            m_tdata,
    output logic [KEEP_WIDTH-1:0]            m_tkeep,
    output logic                             m_tlast,
    output logic [ID_WIDTH-1:0]              grant_id,
    output logic                             busy,
    output logic                             trunc_err,
    output logic [31:0]                      pkt_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FWD   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [ID_WIDTH-1:0]  last_grant;
    logic [ID_WIDTH-1:0]  winner;
    logic [ID_WIDTH-1:0]  scan_idx;
    logic                 found;
    logic [CNT_WIDTH-1:0] beat_cnt;
    logic [NUM_SRC-1:0]   sel_onehot;
    logic                 sel_valid;
    logic                 sel_last;
    logic                 at_limit;
    logic                 fwd_beat;
    logic                 grant_now;

    // Round-robin search starting just after the previous winner.
    always_comb begin
        found    = 1'b0;
        winner   = '0;
        scan_idx = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            scan_idx = ID_WIDTH'((int'(last_grant) + k) % NUM_SRC);
            if (!found && s_tvalid[scan_idx]) begin
                found  = 1'b1;
                winner = scan_idx;
            end
        end
    end

    always_comb begin
        sel_onehot = '0;
        sel_valid  = 1'b0;
        sel_last   = 1'b0;
        m_tdata    = '0;
        m_tkeep    = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant_id == ID_WIDTH'(i)) begin
                sel_onehot[i] = 1'b1;
                sel_valid     = s_tvalid[i];
                sel_last      = s_tlast[i];
                m_tdata       = s_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                m_tkeep       = s_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
            end
        end
    end

    assign at_limit  = (beat_cnt == CNT_WIDTH'(MAX_BEATS - 1));
    assign fwd_beat  = (state == FWD) && sel_valid && m_tready;
    assign grant_now = (state == IDLE) && arb_en && found;
    assign busy      = (state != IDLE);

    always_comb begin
        state_nxt = state;
        s_tready  = '0;
        m_tvalid  = 1'b0;
        m_tlast   = 1'b0;
        case (state)
            IDLE: begin
                if (grant_now)
                    state_nxt = FWD;
            end
            FWD: begin
                m_tvalid = sel_valid;
                m_tlast  = sel_last | at_limit;
                s_tready = sel_onehot & {NUM_SRC{m_tready}};
                if (fwd_beat && (sel_last || at_limit))
                    state_nxt = sel_last ? IDLE : DRAIN;
            end
            DRAIN: begin
                s_tready = sel_onehot;
                if (sel_valid && sel_last)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge user_clk_250) begin
        if (sys_reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge user_clk_250) begin
        if (sys_reset) begin
            last_grant <= ID_WIDTH'(NUM_SRC - 1);
            beat_cnt   <= '0;
            grant_id   <= '0;
            pkt_cnt    <= '0;
            trunc_err  <= 1'b0;
        end else begin
            trunc_err <= 1'b0;
            if (grant_now) begin
                grant_id <= winner;
                beat_cnt <= '0;
            end
            if (fwd_beat) begin
                beat_cnt <= beat_cnt + 1'b1;
                if (sel_last || at_limit) begin
                    pkt_cnt    <= pkt_cnt + 32'd1;
                    last_grant <= grant_id;
                    // Forced tlast: the source still owes the rest of its packet.
                    trunc_err  <= ~sel_last;
                end
            end
        end
    end

endmodule

// File: tb/tb_c2h_stream_arbiter.sv
// Randomized bench for c2h_stream_arbiter: packet-level reference model plus per-source C2H scoreboards.
module tb_c2h_stream_arbiter;
    localparam int N  = 4;
    localparam int DW = 32;
    localparam int KW = 4;
    localparam int MB = 8;
    localparam int IW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            sys_reset = 1'b1;
    logic            arb_en    = 1'b1;
    logic            m_tready  = 1'b1;
    logic [N-1:0]    s_tvalid  = '0;
    logic [N-1:0]    s_tlast   = '0;
    logic [N*DW-1:0] s_tdata   = '0;
    logic [N*KW-1:0] s_tkeep   = '0;
    logic [N-1:0]    s_tready;
    logic            m_tvalid, m_tlast, busy, trunc_err;
    logic [DW-1:0]   m_tdata;
    logic [KW-1:0]   m_tkeep;
    logic [IW-1:0]   grant_id;
    logic [31:0]     pkt_cnt;

    c2h_stream_arbiter #(.NUM_SRC(N), .DATA_WIDTH(DW), .MAX_BEATS(MB)) dut (
        .user_clk_250(clk), .sys_reset(sys_reset), .arb_en(arb_en),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tkeep(s_tkeep),
        .s_tlast(s_tlast), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
        .m_tkeep(m_tkeep), .m_tlast(m_tlast), .grant_id(grant_id), .busy(busy),
        .trunc_err(trunc_err), .pkt_cnt(pkt_cnt)
    );

    int checks = 0;
    int errors = 0;

    logic [36:0] srcq [N][$];   // {last, keep, data} as the source will present it
    logic [37:0] expq [N][$];   // {source last, c2h last, keep, data} expected on C2H
    int          grant_log[$];

    // Model: 0 = no packet owned, 1 = packet flowing to C2H, 2 = discarding tail.
    int          md    = 0;
    int          mg    = 0;
    int          mlast = N - 1;
    logic [31:0] mpkt  = '0;
    logic        mtrunc = 1'b0;

    logic [N-1:0] hs_q = '0;
    int  c2h_beats = 0, trunc_seen = 0, busy_cyc = 0, seq = 0;
    bit  chk_en = 0, rdy_rand = 0, gap_en = 0, flush = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [37:0]  e;
        logic [N-1:0] oh;
        bit           found;
        hs_q = s_tvalid & s_tready;
        if (trunc_err === 1'b1) trunc_seen++;
        if (busy === 1'b1) busy_cyc++;
        if (m_tvalid === 1'b1 && m_tready) c2h_beats++;
        if (chk_en) begin
            chk("busy", busy, md != 0);
            chk("pkt_cnt", pkt_cnt, mpkt);
            chk("trunc_err", trunc_err, mtrunc);
            oh = N'(1) << mg;
            if (md == 0) begin
                chk("idle_s_tready", s_tready, 0);
                chk("idle_m_tvalid", m_tvalid, 0);
                chk("idle_m_tlast", m_tlast, 0);
            end else begin
                chk("grant_id", grant_id, mg);
                if (md == 1) begin
                    chk("fwd_m_tvalid", m_tvalid, s_tvalid[mg]);
                    chk("fwd_s_tready", s_tready, m_tready ? oh : '0);
                    if (m_tvalid === 1'b1) begin
                        if (expq[mg].size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_beat: source %0d sent beat %0h, none expected", mg, m_tdata);
                        end else begin
                            e = expq[mg][0];
                            chk("tdata", m_tdata, e[31:0]);
                            chk("tkeep", m_tkeep, e[35:32]);
                            chk("tlast", m_tlast, e[36]);
                        end
                    end
                end else begin
                    chk("drain_s_tready", s_tready, oh);
                    chk("drain_m_tvalid", m_tvalid, 0);
                end
            end
        end
        mtrunc = 1'b0;
        if (sys_reset) begin
            md    = 0;
            mlast = N - 1;
            mpkt  = '0;
            for (int i = 0; i < N; i++) expq[i].delete();
        end else begin
            case (md)
                0: if (arb_en && s_tvalid != '0) begin
                    found = 0;
                    for (int k = 1; k <= N; k++) begin
                        if (!found && s_tvalid[(mlast + k) % N]) begin
                            found = 1;
                            mg    = (mlast + k) % N;
                        end
                    end
                    grant_log.push_back(mg);
                    md = 1;
                end
                1: if (s_tvalid[mg] && m_tready && expq[mg].size() > 0) begin
                    e = expq[mg].pop_front();
                    if (e[36]) begin
                        mpkt  = mpkt + 1;
                        mlast = mg;
                        if (e[37]) md = 0;
                        else begin
                            md     = 2;
                            mtrunc = 1'b1;
                        end
                    end
                end
                default: if (s_tvalid[mg] && s_tlast[mg]) md = 0;
            endcase
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (hs_q[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
            if (flush) srcq[i].delete();
            if (srcq[i].size() > 0 &&
                ((s_tvalid[i] && !hs_q[i]) || !gap_en || $urandom_range(3) != 0)) begin
                s_tvalid[i] = 1'b1;
                {s_tlast[i], s_tkeep[i*KW +: KW], s_tdata[i*DW +: DW]} = srcq[i][0];
            end else begin
                s_tvalid[i] = 1'b0;
                s_tlast[i]  = 1'b0;
            end
        end
        flush    = 0;
        m_tready = rdy_rand ? 1'($urandom_range(1)) : 1'b1;
    endtask

    task automatic add_pkt(int src, int len);
        for (int k = 0; k < len; k++) begin
            logic [31:0] d  = {4'(src), 12'(seq), 16'($urandom)};
            logic [3:0]  kp = (k == len - 1) ? 4'($urandom_range(1, 15)) : 4'hf;
            seq++;
            srcq[src].push_back({k == len - 1, kp, d});
            if (k < MB) expq[src].push_back({k == len - 1, (k == len - 1) || (k == MB - 1), kp, d});
        end
    endtask

    function automatic bit sources_empty();
        for (int i = 0; i < N; i++) if (srcq[i].size() != 0) return 0;
        return 1;
    endfunction

    function automatic int exp_left();
        int n = 0;
        for (int i = 0; i < N; i++) n += expq[i].size();
        return n;
    endfunction

    task automatic wait_done(int maxc, string name);
        int n = 0;
        while (!(sources_empty() && md == 0) && n < maxc) begin
            step();
            n++;
        end
        if (n >= maxc) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: still busy after %0d cycles, required idle", name, n);
        end
        chk({name, "_leftover_beats"}, exp_left(), 0);
    endtask

    task automatic wait_beats(int target, string name);
        int n = 0;
        while (c2h_beats < target && n < 100) begin
            step();
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL %s_beat_timeout: c2h beats %0d, required %0d", name, c2h_beats, target);
        end
    endtask

    initial begin
        int b0, t0;
        sys_reset = 1'b1;
        step();
        step();
        chk_en = 1;
        step();
        sys_reset = 1'b0;
        chk("reset_pkt_cnt", pkt_cnt, 0);
        chk("reset_busy", busy, 0);

        // T1: all four sources, one 4-beat packet each
        grant_log.delete();
        b0 = busy_cyc;
        for (int s = 0; s < N; s++) add_pkt(s, 4);
        wait_done(200, "T1");
        chk("T1_pkt_cnt", pkt_cnt, 4);
        chk("T1_grants", grant_log.size(), 4);
        for (int i = 0; i < 4; i++) chk("T1_order", grant_log[i], i);
        chk("T1_busy_cycles", busy_cyc - b0, 16);

        // T2: sources 1 and 3 back to back
        grant_log.delete();
        for (int r = 0; r < 4; r++) begin
            add_pkt(1, 2);
            add_pkt(3, 2);
        end
        wait_done(200, "T2");
        chk("T2_grants", grant_log.size(), 8);
        for (int i = 0; i < 8; i++) chk("T2_alternate", grant_log[i], (i % 2 == 0) ? 1 : 3);

        // T3: 12-beat packet on source 2 is cut at MAX_BEATS
        b0 = c2h_beats;
        t0 = trunc_seen;
        add_pkt(2, 12);
        wait_done(200, "T3");
        chk("T3_pkt_cnt", pkt_cnt, 13);
        chk("T3_c2h_beats", c2h_beats - b0, 8);
        chk("T3_trunc_pulses", trunc_seen - t0, 1);

        // T4: random lengths and sources under backpressure and source gaps
        rdy_rand = 1;
        gap_en   = 1;
        for (int p = 0; p < 1000; p++) add_pkt($urandom_range(N - 1), $urandom_range(1, 12));
        wait_done(70000, "T4");
        chk("T4_pkt_cnt", pkt_cnt, 1013);
        rdy_rand = 0;
        gap_en   = 0;

        // T5: arb_en dropped during beat 2
        for (int s = 0; s < N; s++) add_pkt(s, 5);
        b0 = c2h_beats;
        wait_beats(b0 + 1, "T5");
        arb_en = 1'b0;
        for (int i = 0; i < 20; i++) step();
        chk("T5_held_idle", busy, 0);
        chk("T5_one_pkt", pkt_cnt, 1014);
        arb_en = 1'b1;
        step();
        chk("T5_resume", busy, 1);
        wait_done(200, "T5");
        chk("T5_pkt_cnt", pkt_cnt, 1017);

        // T6: reset on beat 3 abandons the packet
        add_pkt(1, 6);
        add_pkt(2, 6);
        b0 = c2h_beats;
        wait_beats(b0 + 2, "T6");
        sys_reset = 1'b1;
        flush     = 1;
        step();
        sys_reset = 1'b0;
        chk("T6_s_tready", s_tready, 0);
        chk("T6_m_tvalid", m_tvalid, 0);
        chk("T6_pkt_cnt", pkt_cnt, 0);
        grant_log.delete();
        for (int s = 0; s < N; s++) add_pkt(s, 4);
        wait_done(200, "T6");
        chk("T6_first_grant", grant_log[0], 0);
        chk("T6_final_pkt_cnt", pkt_cnt, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
